ahb_arbiter: RTL and testbench

Burst-aware AHB bus arbiter for the master side of the synchronous AHB-to-AHB bridge and any other AHB masters sharing that downstream bus. It consumes each master's HBUSREQ, including the bridge's mHBUSREQ. It drives HGRANT back to the masters and HMASTER to the address/data multiplexers. Grant changes only at burst boundaries, so fixed-length bursts from the bridge are never broken. When no master requests, the grant parks on a default master.

---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_arbiter_pick.sv | 44 ++++
 rtl/ahb_arbiter.sv | 115 +++++++++++
 tb/tb_ahb_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB encodings and helpers.
//   htrans_e  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ)
//   hburst_e  - HBURST encodings
//   burst_len - HBURST to beat count (5 bits); INCR returns 0 because its
//               length is set by the master's request, not by a count.
package ahb_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'b000,
    BU_INCR   = 3'b001,
    BU_WRAP4  = 3'b010,
    BU_INCR4  = 3'b011,
    BU_WRAP8  = 3'b100,
    BU_INCR8  = 3'b101,
    BU_WRAP16 = 3'b110,
    BU_INCR16 = 3'b111
  } hburst_e;

  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    logic [4:0] len;
    case (hburst)
      BU_SINGLE:           len = 5'd1;
      BU_INCR:             len = 5'd0;
      BU_WRAP4, BU_INCR4:  len = 5'd4;
      BU_WRAP8, BU_INCR8:  len = 5'd8;
      default:             len = 5'd16;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_arbiter_pick.sv
// ahb_arbiter_pick: combinational winner search over the request vector.
//   req    in  NUM_MASTER  request bits, bit i = master i
//   start  in  4           first index examined (ascending, wrapping)
//   winner out 4           index of the first set request found
//   valid  out 1           at least one request is set
// Build option AHB_ARBITER_ROUND_ROBIN_EN: defined -> search begins at
// `start`; undefined -> search begins at 0 (fixed priority, lowest wins).
module ahb_arbiter_pick #(
  parameter int NUM_MASTER = 4
) (
  input  logic [NUM_MASTER-1:0] req,
  input  logic [3:0]            start,
  output logic [3:0]            winner,
  output logic                  valid
);

  int base;

`ifdef AHB_ARBITER_ROUND_ROBIN_EN
  assign base = int'(start);
`else
  logic unused_start;
  assign unused_start = ^start;
  assign base = 0;
`endif

  always_comb begin
    int idx;
    winner = '0;
    valid  = 1'b0;
    for (int k = 0; k < NUM_MASTER; k++) begin
      idx = base + k;
      if (idx >= NUM_MASTER) idx = idx - NUM_MASTER;
      // Inner loop keeps every bit-select constant after unrolling.
      for (int i = 0; i < NUM_MASTER; i++) begin
        if (!valid && (i == idx) && req[i]) begin
          valid  = 1'b1;
          winner = 4'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// ahb_arbiter: burst-aware AHB arbiter. Grant moves only at burst
// boundaries (IDLE, last beat of a fixed burst, or an INCR burst whose
// owner has dropped its request) and parks on DEFAULT_MASTER when idle.
//   HCLK      in  1           bus clock
//   HRESET    in  1           synchronous reset, active-high
//   HBUSREQ   in  NUM_MASTER  per-master request
//   HTRANS    in  2           muxed HTRANS of current address phase
//   HBURST    in  3           muxed HBURST of current address phase
//   HREADY    in  1           bus-wide ready
//   HGRANT    out NUM_MASTER  one-hot grant (registered)
//   HMASTER   out 4           address-phase owner (registered)
//   HMASTER_D out 4           data-phase owner (registered)
// Build option AHB_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed
// priority (see ahb_arbiter_pick).
module ahb_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTER     = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [NUM_MASTER-1:0] HBUSREQ,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HBURST,
  input  logic                  HREADY,
  output logic [NUM_MASTER-1:0] HGRANT,
  output logic [3:0]            HMASTER,
  output logic [3:0]            HMASTER_D
);

  localparam logic [3:0]            DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTER-1:0] DEF_GRANT = NUM_MASTER'(1) << DEFAULT_MASTER;

  logic [3:0] cnt;
  logic [3:0] last;
  logic [3:0] start;
  logic [3:0] winner;
  logic       win_vld;
  logic [4:0] len;
  logic       cur_req;
  logic       fixed_burst;
  logic       is_xfer;
  logic       last_beat;
  logic       arb_ok;
  logic [3:0] grant_idx;

  assign len         = burst_len(HBURST);
  assign fixed_burst = (HBURST != BU_INCR);
  assign is_xfer     = (HTRANS == TR_NONSEQ) || (HTRANS == TR_SEQ);

  // Request of the current address-phase owner.
  always_comb begin
    cur_req = 1'b0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (HMASTER == 4'(i)) cur_req = HBUSREQ[i];
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MASTER; i++) begin
      if (HGRANT[i]) grant_idx = grant_idx | 4'(i);
    end
  end

  // The beat counter is meaningless for INCR (it is loaded with 15), so the
  // count-based terms are restricted to fixed-length bursts. BUSY never ends
  // a burst.
  assign last_beat = (fixed_burst && (HTRANS == TR_NONSEQ) && (len == 5'd1)) ||
                     (fixed_burst && (HTRANS == TR_SEQ) && (cnt == 4'd1)) ||
                     (!fixed_burst && is_xfer && !cur_req);

  assign arb_ok = HREADY && ((HTRANS == TR_IDLE) || last_beat);

  assign start = (last == 4'(NUM_MASTER - 1)) ? 4'd0 : last + 4'd1;

  ahb_arbiter_pick #(
    .NUM_MASTER (NUM_MASTER)
  ) u_pick (
    .req    (HBUSREQ),
    .start  (start),
    .winner (winner),
    .valid  (win_vld)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT    <= DEF_GRANT;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      cnt       <= '0;
      last      <= DEF_IDX;
    end else begin
      if (HREADY) begin
        HMASTER   <= grant_idx;
        HMASTER_D <= HMASTER;
        if (HTRANS == TR_NONSEQ) begin
          cnt <= 4'(len - 5'd1);
        end else if (HTRANS == TR_SEQ) begin
          cnt <= cnt - 4'd1;
        end
      end
      if (arb_ok) begin
        if (win_vld) begin
          HGRANT <= NUM_MASTER'(1) << winner;
          last   <= winner;
        end else begin
          HGRANT <= DEF_GRANT;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb_ahb_arbiter: directed scenarios plus randomized legal burst traffic,
// checked every cycle against a transaction-level reference model.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int NM  = 4;
  localparam int DEF = 0;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [NM-1:0] HBUSREQ;
  logic [1:0]    HTRANS;
  logic [2:0]    HBURST;
  logic          HREADY;
  logic [NM-1:0] HGRANT;
  logic [3:0]    HMASTER;
  logic [3:0]    HMASTER_D;

  int total = 0;
  int bad   = 0;

  // Reference model state: owner indices and position within the burst.
  int m_grant, m_master, m_master_d, m_last, m_beat;

  ahb_arbiter #(.NUM_MASTER(NM), .DEFAULT_MASTER(DEF)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HBUSREQ   (HBUSREQ),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HREADY    (HREADY),
    .HGRANT    (HGRANT),
    .HMASTER   (HMASTER),
    .HMASTER_D (HMASTER_D)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int blen(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return 0;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  // Apply one clock edge's worth of the arbitration rules to the model.
  task automatic model_edge();
    int  len, win, c;
    bit  lb, arb;
    if (HRESET) begin
      m_grant = DEF; m_master = DEF; m_master_d = DEF; m_last = DEF; m_beat = 0;
      return;
    end
    if (!HREADY) return;
    len = blen(HBURST);
    lb  = 0;
    if (HBURST != BU_INCR) begin
      if (HTRANS == TR_NONSEQ && len == 1) lb = 1;
      if (HTRANS == TR_SEQ && m_beat + 1 == len) lb = 1;
    end else if ((HTRANS == TR_NONSEQ || HTRANS == TR_SEQ) && !HBUSREQ[m_master]) begin
      lb = 1;
    end
    if (HTRANS == TR_NONSEQ) m_beat = 1;
    else if (HTRANS == TR_SEQ) m_beat = m_beat + 1;
    arb = (HTRANS == TR_IDLE) || lb;
    m_master_d = m_master;
    m_master   = m_grant;
    if (arb) begin
      win = -1;
      for (int k = 0; k < NM; k++) begin
`ifdef AHB_ARBITER_ROUND_ROBIN_EN
        c = (m_last + 1 + k) % NM;
`else
        c = k;
`endif
        if (win < 0 && HBUSREQ[c]) win = c;
      end
      if (win >= 0) begin
        m_grant = win;
        m_last  = win;
      end else begin
        m_grant = DEF;
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] req, input logic [1:0] tr,
                      input logic [2:0] bu, input logic rdy);
    HRESET = r; HBUSREQ = req; HTRANS = tr; HBURST = bu; HREADY = rdy;
    model_edge();
    @(posedge HCLK);
    @(negedge HCLK);
    check_eq("hgrant", int'(HGRANT), 1 << m_grant);
    check_eq("hmaster", int'(HMASTER), m_master);
    check_eq("hmaster_d", int'(HMASTER_D), m_master_d);
  endtask

  initial begin
    logic [3:0] rr_exp [4];
    logic [3:0] req;
    logic [1:0] tr;
    logic [2:0] bu;
    logic       rdy, rst, prev_rdy;
    int         left;

    // Reset with requests pending.
    step(1, 4'b1010, TR_IDLE, BU_SINGLE, 1);
    step(1, 4'b1010, TR_IDLE, BU_SINGLE, 1);
    check_eq("rst_grant", int'(HGRANT), 4'b0001);
    check_eq("rst_master", int'(HMASTER), 0);
    check_eq("rst_master_d", int'(HMASTER_D), 0);

    // INCR4 owned by master 2; master 1 waits for the burst end.
    step(0, 4'b0100, TR_IDLE, BU_SINGLE, 1);
    check_eq("incr4_win", int'(HGRANT), 4'b0100);
    step(0, 4'b0110, TR_NONSEQ, BU_INCR4, 1);
    check_eq("incr4_b1", int'(HGRANT), 4'b0100);
    step(0, 4'b0110, TR_SEQ, BU_INCR4, 1);
    step(0, 4'b0110, TR_SEQ, BU_INCR4, 1);
    check_eq("incr4_b3", int'(HGRANT), 4'b0100);
    step(0, 4'b0110, TR_SEQ, BU_INCR4, 1);
    check_eq("incr4_hand", int'(HGRANT), 4'b0010);

    // INCR8 from master 1 with a 3-cycle stall on beat 5.
    step(0, 4'b0010, TR_IDLE, BU_SINGLE, 1);
    check_eq("incr8_win", int'(HGRANT), 4'b0010);
    step(0, 4'b1010, TR_NONSEQ, BU_INCR8, 1);
    for (int b = 2; b <= 4; b++) step(0, 4'b1010, TR_SEQ, BU_INCR8, 1);
    for (int s = 0; s < 3; s++) begin
      step(0, 4'b1010, TR_SEQ, BU_INCR8, 0);
      check_eq("stall_grant", int'(HGRANT), 4'b0010);
      check_eq("stall_master", int'(HMASTER), 1);
    end
    for (int b = 5; b <= 7; b++) step(0, 4'b1010, TR_SEQ, BU_INCR8, 1);
    check_eq("incr8_b7", int'(HGRANT), 4'b0010);
    step(0, 4'b1010, TR_SEQ, BU_INCR8, 1);
`ifdef AHB_ARBITER_ROUND_ROBIN_EN
    check_eq("incr8_hand", int'(HGRANT), 4'b1000);
`else
    check_eq("incr8_hand", int'(HGRANT), 4'b0010);
`endif

    // All masters requesting, back-to-back SINGLE transfers.
    step(1, 4'b1111, TR_IDLE, BU_SINGLE, 1);
`ifdef AHB_ARBITER_ROUND_ROBIN_EN
    rr_exp = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`else
    rr_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    for (int i = 0; i < 4; i++) begin
      step(0, 4'b1111, TR_NONSEQ, BU_SINGLE, 1);
      check_eq("rr_seq", int'(HGRANT), int'(rr_exp[i]));
    end

    // INCR undefined length: master 1 drops request, master 3 takes over.
    step(1, 4'b0000, TR_IDLE, BU_SINGLE, 1);
    step(0, 4'b0010, TR_IDLE, BU_SINGLE, 1);
    step(0, 4'b0010, TR_IDLE, BU_SINGLE, 1);
    check_eq("incr_own", int'(HMASTER), 1);
    step(0, 4'b1010, TR_NONSEQ, BU_INCR, 1);
    for (int b = 0; b < 5; b++) begin
      step(0, 4'b1010, TR_SEQ, BU_INCR, 1);
      check_eq("incr_hold", int'(HGRANT), 4'b0010);
    end
    step(0, 4'b1000, TR_SEQ, BU_INCR, 1);
    check_eq("incr_hand", int'(HGRANT), 4'b1000);

    // Parking on the default master.
    step(0, 4'b0000, TR_IDLE, BU_SINGLE, 1);
    check_eq("park_grant", int'(HGRANT), 4'b0001);
    step(0, 4'b0000, TR_IDLE, BU_SINGLE, 1);
    check_eq("park_master", int'(HMASTER), DEF);

    // Randomized legal burst traffic.
    step(1, 4'b0000, TR_IDLE, BU_SINGLE, 1);
    req = 4'b0000; tr = TR_IDLE; bu = BU_SINGLE; left = 0; prev_rdy = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (prev_rdy) begin
        if (left > 0) begin
          if ($urandom_range(0, 9) == 0) begin
            tr = TR_BUSY;
          end else begin
            tr = TR_SEQ;
            left--;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          tr = TR_IDLE;
        end else begin
          bu   = 3'($urandom_range(0, 7));
          left = (bu == BU_INCR) ? int'($urandom_range(1, 8)) : blen(bu);
          left = left - 1;
          tr   = TR_NONSEQ;
        end
      end
      for (int i = 0; i < NM; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      end
      rdy = ($urandom_range(0, 4) != 0);
      rst = (left == 0) && ($urandom_range(0, 199) == 0);
      step(rst, req, tr, bu, rdy);
      prev_rdy = rdy | rst;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
